// File: rtl/s_ram.sv
// ---------------------------------------------------------------------------
// s_ram : single-port synchronous RAM, one shared address bus.
//
// Each rising clock edge performs exactly one operation chosen by en:
//   en = 1 : write  mem[addr] <= data_in   (data_out holds its value)
//   en = 0 : read   data_out  <= mem[addr] (one-cycle latency)
// A reset edge (rst = 1) clears data_out and every memory word at once and
// blocks any write that would otherwise happen in that cycle.
//
// Ports:
//   clk       in   1           system clock, all state on rising edge
//   rst       in   1           synchronous, active-high reset
//   en        in   1           mode select: 1 = write, 0 = read
//   addr      in   ADDR_WIDTH  word address for both write and read
//   data_in   in   DATA_WIDTH  write data
//   data_out  out  DATA_WIDTH  registered read data
//
// Handshake: none. Every cycle is an accepted operation; there is no
// valid/ready pair because the RAM can always take one access per clock.
// ---------------------------------------------------------------------------
module s_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  // Depth expressed one bit wider than addr so the range compare also works
  // when DEPTH == 2**ADDR_WIDTH (every address is then in range).
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  // Storage is plain flops: reset must clear every word in a single edge,
  // which a RAM macro could not do.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_out;

  logic                  w_in_range;
  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // No wrap: addresses at or above DEPTH are simply outside the memory.
  assign w_in_range = ({1'b0, addr} < LP_DEPTH);
  assign w_wr       = en && w_in_range;

  // Out-of-range reads return zero rather than an aliased word.
  always_comb begin
    w_rd_data = '0;
    if (w_in_range) begin
      w_rd_data = r_mem[addr];
    end
  end

  // Memory array: reset beats any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[addr] <= data_in;
    end
  end

  // Read register: updated only on read cycles, so it holds across writes
  // and there is no write-through path from data_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out <= '0;
    end else if (!en) begin
      r_data_out <= w_rd_data;
    end
  end

  assign data_out = r_data_out;

endmodule

// File: tb/tb_s_ram.sv
// ---------------------------------------------------------------------------
// tb_s_ram : self-checking bench for s_ram.
// Directed scenarios followed by randomized operations; every cycle's
// data_out is compared against a behavioural memory model.
// ---------------------------------------------------------------------------
module tb_s_ram;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          en;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;

  int n_vec;
  int n_err;

  // Reference model: an array of words plus the last read value.
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_out;
  logic [DW-1:0] exp_q [$];

  s_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [DW-1:0] obs,
                           input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_step(input logic m_rst, input logic m_en,
                            input logic [AW-1:0] m_addr,
                            input logic [DW-1:0] m_din);
    if (m_rst) begin
      foreach (model_mem[i]) model_mem[i] = '0;
      model_out = '0;
    end else if (m_en) begin
      model_mem[m_addr] = m_din;
    end else begin
      model_out = model_mem[m_addr];
    end
    exp_q.push_back(model_out);
  endtask

  // ---------------- driver ----------------
  // Drives one operation on the falling edge, lets the rising edge take it,
  // then checks data_out 1 time unit after that edge.
  task automatic drive_op(input string tag, input logic d_rst, input logic d_en,
                          input logic [AW-1:0] d_addr,
                          input logic [DW-1:0] d_din);
    logic [DW-1:0] exp;
    @(negedge clk);
    rst     = d_rst;
    en      = d_en;
    addr    = d_addr;
    data_in = d_din;
    @(posedge clk);
    #1;
    model_step(d_rst, d_en, d_addr, d_din);
    exp = exp_q.pop_front();
    check_val(tag, data_out, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] k_data;
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    en      = 1'b0;
    addr    = '0;
    data_in = '0;
    foreach (model_mem[i]) model_mem[i] = 'x;
    model_out = 'x;

    // Reset held 2 cycles with a write pending: write must be blocked.
    drive_op("reset_c0", 1'b1, 1'b1, 4'd3, 8'hAA);
    drive_op("reset_c1", 1'b1, 1'b1, 4'd3, 8'hAA);
    check_val("reset_out_zero", data_out, 8'h00);
    drive_op("rd3_after_reset", 1'b0, 1'b0, 4'd3, 8'h00);
    check_val("rd3_blocked", data_out, 8'h00);

    // Basic write then read.
    drive_op("wr5", 1'b0, 1'b1, 4'd5, 8'h3C);
    drive_op("rd5", 1'b0, 1'b0, 4'd5, 8'h00);
    check_val("rd5_value", data_out, 8'h3C);

    // data_out holds during a write.
    drive_op("wr2_hold", 1'b0, 1'b1, 4'd2, 8'h77);
    check_val("hold_during_wr", data_out, 8'h3C);

    // Full sweep with k*17, then read back.
    for (int k = 0; k < DEPTH; k++) begin
      k_data = 8'(k * 17);
      drive_op("sweep_wr", 1'b0, 1'b1, AW'(k), k_data);
    end
    for (int k = 0; k < DEPTH; k++) begin
      k_data = 8'(k * 17);
      drive_op("sweep_rd", 1'b0, 1'b0, AW'(k), 8'h00);
      check_val("sweep_const", data_out, k_data);
    end

    // Overwrite.
    drive_op("ow_wr1", 1'b0, 1'b1, 4'd9, 8'h11);
    drive_op("ow_wr2", 1'b0, 1'b1, 4'd9, 8'hEE);
    drive_op("ow_rd", 1'b0, 1'b0, 4'd9, 8'h00);
    check_val("ow_value", data_out, 8'hEE);

    // Back-to-back write/read alternation on one address.
    for (int i = 0; i < 8; i++) begin
      k_data = 8'($urandom_range(0, 255));
      drive_op("b2b_wr", 1'b0, 1'b1, 4'd12, k_data);
      drive_op("b2b_rd", 1'b0, 1'b0, 4'd12, 8'h00);
      check_val("b2b_value", data_out, k_data);
    end

    // Reset mid-operation.
    for (int k = 0; k < 4; k++) begin
      drive_op("mid_fill", 1'b0, 1'b1, AW'(k), 8'(8'hA0 + k));
    end
    drive_op("mid_rd1", 1'b0, 1'b0, 4'd1, 8'h00);
    check_val("mid_pre_reset", data_out, 8'hA1);
    drive_op("mid_reset", 1'b1, 1'b0, 4'd1, 8'h00);
    check_val("mid_reset_out", data_out, 8'h00);
    for (int k = 0; k < 4; k++) begin
      drive_op("mid_rd", 1'b0, 1'b0, AW'(k), 8'h00);
      check_val("mid_cleared", data_out, 8'h00);
    end

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      drive_op("rand",
               ($urandom_range(0, 59) == 0),
               1'($urandom_range(0, 1)),
               AW'($urandom_range(0, DEPTH - 1)),
               DW'($urandom_range(0, 255)));
    end

    // Final readback of the whole memory against the model.
    for (int k = 0; k < DEPTH; k++) begin
      drive_op("final_rd", 1'b0, 1'b0, AW'(k), 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
